ser_tx: RTL and testbench

- Parallel-in, serial-out framed transmitter: the transmit end of the single-wire serial link; the matching receiver already exists in the block library.
- Accepts one DATA_W-bit word per valid/ready handshake and shifts it out as:
  - a start bit (0);
  - the data bits, LSB first;
  - a stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.
- tx_out is driven directly from a flip-flop, so the line is glitch-free into the receiver.

---
 rtl/ser_tx.sv | 137 +++++++++++++
 tb/tb_ser_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ser_tx.sv
// rtl/ser_tx.sv - framed serial transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Optional even-parity bit between data and stop when PARITY_EN is defined.
module ser_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              CLK,
    input  logic              n_Reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    generate
        if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
            $error("ser_tx: DATA_W out of range 1..16");
        end
        if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 256) begin : g_bad_clks
            $error("ser_tx: CLKS_PER_BIT out of range 1..256");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state;
    logic [BAUD_W-1:0]   baud;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   shift_next;
    logic                bit_end;
`ifdef PARITY_EN
    logic                par;
`endif

    assign shift_next = shift >> 1;
    assign bit_end    = (baud == BAUD_LAST);

    always_ff @(posedge CLK) begin
        if (!n_Reset) begin
            state    <= IDLE;
            baud     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
`ifdef PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                baud <= bit_end ? '0 : baud + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shift    <= tx_data;
                        baud     <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                        tx_out   <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef PARITY_EN
                        par      <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        tx_out <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift   <= shift_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef PARITY_EN
                            state  <= PARITY;
                            tx_out <= par;
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            tx_out <= shift_next[0];
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    // tx_ready and tx_done rise together on the last stop-bit edge
                    if (bit_end) begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        tx_done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_out   <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_tx.sv
// tb/tb_ser_tx.sv - scoreboard bench for ser_tx across three parameter sets.
module tb_ser_tx;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [2:0] valid;
    logic [7:0] data_a, data_b;
    logic [0:0] data_c;
    logic [2:0] out_w, busy_w, done_w, ready_w;

    always #5 clk = ~clk;

    ser_tx #(.DATA_W(8), .CLKS_PER_BIT(2)) u_a (
        .CLK(clk), .n_Reset(n_reset), .tx_data(data_a), .tx_valid(valid[0]),
        .tx_ready(ready_w[0]), .tx_out(out_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
    ser_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_b (
        .CLK(clk), .n_Reset(n_reset), .tx_data(data_b), .tx_valid(valid[1]),
        .tx_ready(ready_w[1]), .tx_out(out_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
    ser_tx #(.DATA_W(1), .CLKS_PER_BIT(256)) u_c (
        .CLK(clk), .n_Reset(n_reset), .tx_data(data_c), .tx_valid(valid[2]),
        .tx_ready(ready_w[2]), .tx_out(out_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));

    // Frames listed bit 0 first: start, data LSB first, [parity], stop
`ifdef PARITY_EN
    localparam int NB8 = 11;
    localparam int NB1 = 4;
    localparam logic [31:0] F_A5 = 32'b1_0_10100101_0;
    localparam logic [31:0] F_3C = 32'b1_0_00111100_0;
    localparam logic [31:0] F_FF = 32'b1_0_11111111_0;
    localparam logic [31:0] F_00 = 32'b1_0_00000000_0;
    localparam logic [31:0] F_81 = 32'b1_0_10000001_0;
    localparam logic [31:0] F_1  = 32'b1_1_1_0;
`else
    localparam int NB8 = 10;
    localparam int NB1 = 3;
    localparam logic [31:0] F_A5 = 32'b1_10100101_0;
    localparam logic [31:0] F_3C = 32'b1_00111100_0;
    localparam logic [31:0] F_FF = 32'b1_11111111_0;
    localparam logic [31:0] F_00 = 32'b1_00000000_0;
    localparam logic [31:0] F_81 = 32'b1_10000001_0;
    localparam logic [31:0] F_1  = 32'b1_1_0;
`endif

    typedef struct {
        int          id;
        logic [31:0] bits;
        int          nbits;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cpb[3]   = '{2, 1, 256};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: rebuilds each frame from tx_out and checks it when tx_done pulses
    int          cnt[3], nb[3], idle[3];
    logic [31:0] cap[3];
    logic [2:0]  busy_p = '0, done_p = '0;

    initial begin
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0; nb[i] = 0; idle[i] = 1000; cap[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_w[i] === 1'b1 && busy_p[i] !== 1'b1) begin
                if (q.size() > 0 && q[0].gap >= 0)
                    chk($sformatf("gap_dut%0d", i), idle[i], q[0].gap);
                cnt[i] = 0; nb[i] = 0; cap[i] = '0;
            end
            if (busy_w[i] === 1'b1) begin
                if (cnt[i] % cpb[i] == 0) begin
                    cap[i][nb[i]] = out_w[i];
                    nb[i]++;
                end else begin
                    chk($sformatf("bit_hold_dut%0d", i), out_w[i], cap[i][nb[i]-1]);
                end
                cnt[i]++;
            end else begin
                idle[i]++;
            end
            if (done_w[i] === 1'b1) begin
                chk($sformatf("done_width_dut%0d", i), done_p[i], 1'b0);
                if (q.size() == 0) begin
                    chk($sformatf("unexpected_done_dut%0d", i), 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("frame_dut_id%0d", i), i, e.id);
                    chk($sformatf("frame_bits_dut%0d", i), cap[i], e.bits);
                    chk($sformatf("frame_nbits_dut%0d", i), nb[i], e.nbits);
                    chk($sformatf("frame_len_dut%0d", i), cnt[i], e.nbits * cpb[i]);
                    chk($sformatf("ready_at_done_dut%0d", i), ready_w[i], 1'b1);
                    chk($sformatf("idle_line_dut%0d", i), out_w[i], 1'b1);
                end
                idle[i] = 1;
            end
            busy_p[i] = busy_w[i];
            done_p[i] = done_w[i];
        end
    end

    task automatic drive(input int id, input logic [7:0] d, input logic v);
        case (id)
            0: data_a = d;
            1: data_b = d;
            default: data_c = d[0];
        endcase
        valid[id] = v;
    endtask

    task automatic push(input int id, input logic [31:0] bits, input int nbits, input int gap);
        exp_t e;
        e.id = id; e.bits = bits; e.nbits = nbits; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic wait_done(input int id, input int budget);
        int t = 0;
        while (done_w[id] !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (done_w[id] !== 1'b1) chk($sformatf("timeout_dut%0d", id), 0, 1);
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic [31:0] bits, input int nbits);
        push(id, bits, nbits, -1);
        drive(id, d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        valid[id] = 1'b0;
        wait_done(id, 4000);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_reset = 1'b0;
        valid   = 3'b111;
        data_a  = 8'hA5; data_b = 8'h81; data_c = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_out_dut%0d", i), out_w[i], 1'b1);
            chk($sformatf("reset_ready_dut%0d", i), ready_w[i], 1'b1);
            chk($sformatf("reset_busy_dut%0d", i), busy_w[i], 1'b0);
            chk($sformatf("reset_done_dut%0d", i), done_w[i], 1'b0);
        end
        valid   = 3'b000;
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        send(0, 8'hA5, F_A5, NB8);

        // tx_valid held through the first frame while tx_data changes
        push(0, F_3C, NB8, -1);
        push(0, F_FF, NB8, 1);
        drive(0, 8'h3C, 1'b1);
        @(posedge clk);
        repeat (5) @(negedge clk);
        data_a = 8'hFF;
        wait_done(0, 200);
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        wait_done(0, 200);
        repeat (2) @(negedge clk);

        push(1, F_00, NB8, -1);
        push(1, F_FF, NB8, 1);
        drive(1, 8'h00, 1'b1);
        @(posedge clk);
        @(negedge clk);
        data_b = 8'hFF;
        wait_done(1, 100);
        @(posedge clk);
        @(negedge clk);
        valid[1] = 1'b0;
        wait_done(1, 100);
        repeat (2) @(negedge clk);

        // Abandon a frame with a one-edge reset during data bit 3
        drive(1, 8'h81, 1'b1);
        @(posedge clk);
        @(negedge clk);
        valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        chk("midreset_out", out_w[1], 1'b1);
        chk("midreset_ready", ready_w[1], 1'b1);
        chk("midreset_busy", busy_w[1], 1'b0);
        chk("midreset_done", done_w[1], 1'b0);
        repeat (12) @(negedge clk);
        chk("midreset_stays_idle", busy_w[1], 1'b0);
        send(1, 8'h81, F_81, NB8);

        send(2, 8'h01, F_1, NB1);

        chk("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
